// File: rtl/gps_acq_pkg.sv
// Shared acquisition definitions for the satellite search channels.
//   acq_state_e        : sweep controller states (IDLE, SEARCH, DONE)
//   NUM_PHASES_DEFAULT : code phases per sweep (1023 chips, half-chip steps)
//   EW_DEFAULT         : width of the squared-accumulator energies
//   phase_t            : phase index type sized for the default sweep length
package gps_acq_pkg;

  localparam int NUM_PHASES_DEFAULT = 2046;
  localparam int EW_DEFAULT         = 28;

  typedef logic [$clog2(NUM_PHASES_DEFAULT)-1:0] phase_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } acq_state_e;

endpackage

// File: rtl/acq_peak_detect_if.sv
// Control/data bundle between the acquisition sequencer and one peak detector.
//   master : drives start/abort/dump/energy_i/energy_q/threshold, observes results
//   slave  : the detector; drives phase_adv/busy/done/detected/peak_phase/peak_energy
// Parameters EW and NUM_PHASES must match those of the attached acq_peak_detect.
interface acq_peak_detect_if #(
  parameter int EW         = 28,
  parameter int NUM_PHASES = 2046
);
  localparam int PW = $clog2(NUM_PHASES);

  logic          start;
  logic          abort;
  logic          dump;
  logic [EW-1:0] energy_i;
  logic [EW-1:0] energy_q;
  logic [EW:0]   threshold;
  logic          phase_adv;
  logic          busy;
  logic          done;
  logic          detected;
  logic [PW-1:0] peak_phase;
  logic [EW:0]   peak_energy;

  modport master (
    output start, abort, dump, energy_i, energy_q, threshold,
    input  phase_adv, busy, done, detected, peak_phase, peak_energy
  );

  modport slave (
    input  start, abort, dump, energy_i, energy_q, threshold,
    output phase_adv, busy, done, detected, peak_phase, peak_energy
  );
endinterface

// File: rtl/acq_max_tracker.sv
// Running maximum of sweep energies and the phase where it occurred.
// With PEAK_RATIO_EN defined it also keeps the second-highest energy and
// reports whether the max clears second + (second >> RATIO_SHIFT).
//   clear_i      : zero all tracked values (new sweep)
//   eval_i       : energy_i/phase_i belong to an evaluated dump
//   max_o        : registered sweep maximum
//   peak_phase_o : registered phase of the maximum
//   max_next_o   : maximum including this cycle's dump (for end-of-sweep decision)
//   ratio_ok_o   : peak-ratio test on the post-update values (constant 1 when disabled)
module acq_max_tracker #(
  parameter int EW = 28,
  parameter int PW = 11
`ifdef PEAK_RATIO_EN
  , parameter int RATIO_SHIFT = 2
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          eval_i,
  input  logic [EW:0]   energy_i,
  input  logic [PW-1:0] phase_i,
  output logic [EW:0]   max_o,
  output logic [PW-1:0] peak_phase_o,
  output logic [EW:0]   max_next_o,
  output logic          ratio_ok_o
);

  logic [EW:0]   max_q, max_d;
  logic [PW-1:0] phase_q, phase_d;
`ifdef PEAK_RATIO_EN
  logic [EW:0]   second_q, second_d;
  logic [EW+1:0] margin;
`endif

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    max_d   = max_q;
    phase_d = phase_q;
`ifdef PEAK_RATIO_EN
    second_d = second_q;
`endif
    if (clear_i) begin
      max_d   = '0;
      phase_d = '0;
`ifdef PEAK_RATIO_EN
      second_d = '0;
`endif
    end else if (eval_i) begin
      // Strict compare: equal energies keep the earlier phase.
      if (energy_i > max_q) begin
        max_d   = energy_i;
        phase_d = phase_i;
`ifdef PEAK_RATIO_EN
        second_d = max_q;
      end else if (energy_i > second_q) begin
        second_d = energy_i;
`endif
      end
    end
  end

  // NOTE: registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q   <= '0;
      phase_q <= '0;
`ifdef PEAK_RATIO_EN
      second_q <= '0;
`endif
    end else begin
      max_q   <= max_d;
      phase_q <= phase_d;
`ifdef PEAK_RATIO_EN
      second_q <= second_d;
`endif
    end
  end

`ifdef PEAK_RATIO_EN
  // One extra bit so second + second/2^k cannot wrap.
  assign margin     = {1'b0, second_d} + {1'b0, second_d >> RATIO_SHIFT};
  assign ratio_ok_o = {1'b0, max_d} > margin;
`else
  assign ratio_ok_o = 1'b1;
`endif

  assign max_o        = max_q;
  assign peak_phase_o = phase_q;
  assign max_next_o   = max_d;

endmodule

// File: rtl/acq_peak_detect.sv
// Acquisition back-end for one satellite search channel. Each evaluated dump
// forms E = I^2 + Q^2, tracks the strongest code phase across a full sweep,
// and steps the code generator by a half-chip (phase_adv) after each phase.
// The first SETTLE_DUMPS dumps after every phase step are discarded because
// they span a partial code period.
//   clk, rst : clock, asynchronous active-high reset
//   acq_if   : slave side of acq_peak_detect_if (start/abort/dump/energies/threshold in;
//              phase_adv/busy/done/detected/peak_phase/peak_energy out)
// Build option: define PEAK_RATIO_EN to additionally require the max to exceed
// the second-highest energy by the RATIO_SHIFT margin before declaring detection.
module acq_peak_detect
  import gps_acq_pkg::*;
#(
  parameter int NUM_PHASES   = NUM_PHASES_DEFAULT,
  parameter int SETTLE_DUMPS = 1,
  parameter int EW           = EW_DEFAULT
`ifdef PEAK_RATIO_EN
  , parameter int RATIO_SHIFT = 2
`endif
) (
  input logic              clk,
  input logic              rst,
  acq_peak_detect_if.slave acq_if
);

  localparam int PW = $clog2(NUM_PHASES);
  localparam int SW = (SETTLE_DUMPS > 0) ? $clog2(SETTLE_DUMPS + 1) : 1;
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_DUMPS);
  localparam logic [PW-1:0] LAST_PHASE  = PW'(NUM_PHASES - 1);

  acq_state_e    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [EW:0]   thr_q, thr_d;
  logic          adv_q, adv_d;
  logic          det_q, det_d;

  logic          launch, eval;
  logic [EW:0]   energy;
  logic [EW:0]   max_next;
  logic          ratio_ok;
  logic [EW:0]   peak_energy;
  logic [PW-1:0] peak_phase;

  // Both inputs are < 2^EW, so the EW+1-bit sum cannot overflow.
  assign energy = {1'b0, acq_if.energy_i} + {1'b0, acq_if.energy_q};

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    settle_d = settle_q;
    thr_d    = thr_q;
    adv_d    = 1'b0;
    det_d    = det_q;
    launch   = 1'b0;
    eval     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        // abort wins over a simultaneous start
        if (acq_if.start && !acq_if.abort) begin
          launch   = 1'b1;
          state_d  = SEARCH;
          phase_d  = '0;
          settle_d = SETTLE_INIT;
          thr_d    = acq_if.threshold;
          det_d    = 1'b0;
        end
      end
      SEARCH: begin
        if (acq_if.abort) begin
          state_d = IDLE;
        end else if (acq_if.dump) begin
          if (settle_q != '0) begin
            settle_d = settle_q - SW'(1);
          end else begin
            eval = 1'b1;
            if (phase_q == LAST_PHASE) begin
              state_d = DONE;
              // Decide on the max including this final dump.
              det_d   = (max_next > thr_q) && ratio_ok;
            end else begin
              adv_d    = 1'b1;
              phase_d  = phase_q + PW'(1);
              settle_d = SETTLE_INIT;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      settle_q <= '0;
      thr_q    <= '0;
      adv_q    <= 1'b0;
      det_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      settle_q <= settle_d;
      thr_q    <= thr_d;
      adv_q    <= adv_d;
      det_q    <= det_d;
    end
  end

  acq_max_tracker #(
    .EW(EW),
    .PW(PW)
`ifdef PEAK_RATIO_EN
    , .RATIO_SHIFT(RATIO_SHIFT)
`endif
  ) u_max_tracker (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (launch),
    .eval_i      (eval),
    .energy_i    (energy),
    .phase_i     (phase_q),
    .max_o       (peak_energy),
    .peak_phase_o(peak_phase),
    .max_next_o  (max_next),
    .ratio_ok_o  (ratio_ok)
  );

  assign acq_if.phase_adv   = adv_q;
  assign acq_if.busy        = (state_q == SEARCH);
  assign acq_if.done        = (state_q == DONE);
  assign acq_if.detected    = det_q;
  assign acq_if.peak_phase  = peak_phase;
  assign acq_if.peak_energy = peak_energy;

endmodule
